// File: rtl/beta_pkg.sv
// rtl/beta_pkg.sv - shared types and helpers for the instruction-memory bridge
package beta_pkg;

    localparam int IMEM_WORD_LSB = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } imem_state_t;

    typedef struct packed {
        logic [29:0] tag;
        logic [31:0] data;
        logic        err;
        logic        valid;
    } imem_entry_t;

    function automatic logic [29:0] word_tag(input logic [31:0] addr);
        return addr[31:IMEM_WORD_LSB];
    endfunction

    function automatic logic [31:0] tag_to_addr(input logic [29:0] tag);
        return {tag, {IMEM_WORD_LSB{1'b0}}};
    endfunction

endpackage

// File: rtl/imem_stream_buf.sv
// rtl/imem_stream_buf.sv - two-entry sequential stream buffer with hit/advance and fill ports
module imem_stream_buf
    import beta_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] fetch_tag,
    input  logic        inv_all,
    input  logic        fill0_en,
    input  logic        fill1_en,
    input  logic [29:0] fill_tag,
    input  logic [31:0] fill_data,
    input  logic        fill_err,
    output logic        hit,
    output logic [31:0] hit_data,
    output logic        hit_err,
    output logic        e0_hit,
    output logic        e0_valid,
    output logic [29:0] e0_tag,
    output logic        e0_err,
    output logic        e1_valid
);

    imem_entry_t e0_q, e0_d;
    imem_entry_t e1_q, e1_d;
    imem_entry_t fill_entry;
    logic        e1_hit;
    imem_entry_t sel;

    assign e0_hit   = e0_q.valid && (e0_q.tag == fetch_tag);
    assign e1_hit   = e1_q.valid && (e1_q.tag == fetch_tag);
    assign hit      = e0_hit || e1_hit;
    assign e0_valid = e0_q.valid;
    assign e0_tag   = e0_q.tag;
    assign e0_err   = e0_q.err;
    assign e1_valid = e1_q.valid;

    always_comb begin
        sel = e0_hit ? e0_q : e1_q;
        hit_err  = 1'b0;
        hit_data = 32'h0;
        if (hit) begin
            hit_err  = sel.err;
            // A faulted entry never exposes its bus data to fetch.
            hit_data = sel.err ? 32'h0 : sel.data;
        end
    end

    always_comb begin
        fill_entry.tag   = fill_tag;
        fill_entry.data  = fill_data;
        fill_entry.err   = fill_err;
        fill_entry.valid = 1'b1;
    end

    // Fills are applied last so a demand response lands even in a miss cycle.
    always_comb begin
        e0_d = e0_q;
        e1_d = e1_q;
        if (inv_all) begin
            e0_d.valid = 1'b0;
            e1_d.valid = 1'b0;
        end else if (e1_hit && !e0_hit) begin
            e0_d       = e1_q;
            e1_d.valid = 1'b0;
        end
        if (fill0_en) begin
            e0_d = fill_entry;
        end
        if (fill1_en) begin
            e1_d = fill_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q <= '0;
            e1_q <= '0;
        end else begin
            e0_q <= e0_d;
            e1_q <= e1_d;
        end
    end

endmodule

// File: rtl/imem_bridge.sv
// rtl/imem_bridge.sv - fetch-side instruction memory bridge with sequential prefetch
module imem_bridge
    import beta_pkg::*;
#(
    parameter bit PREFETCH = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fetch_addr,
    output logic [31:0] fetch_data,
    output logic        fetch_fault,
    output logic        mem_stall,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err
);

    imem_state_t state_q, state_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        req_is_pf_q, req_is_pf_d;
    logic        discard_q, discard_d;

    logic [29:0] fetch_tag;
    logic [29:0] req_tag;
    logic        hit;
    logic [31:0] hit_data;
    logic        hit_err;
    logic        e0_hit;
    logic        e0_valid;
    logic [29:0] e0_tag;
    logic        e0_err;
    logic        e1_valid;
    logic        busy;
    logic        rsp_take;
    logic        rsp_keep;
    logic        fill0_en;
    logic        fill1_en;
    logic        pf_match;
    logic        pf_want;
    logic        stale_req;
    logic        unused_addr_lsbs;

    assign fetch_tag        = word_tag(fetch_addr);
    assign req_tag          = word_tag(req_addr_q);
    assign unused_addr_lsbs = ^{fetch_addr[1:0], req_addr_q[1:0]};

    assign mem_stall   = !hit;
    assign fetch_data  = hit_data;
    assign fetch_fault = hit_err;

    assign mem_req_valid = (state_q == REQ);
    assign mem_req_addr  = req_addr_q;

    assign busy     = (state_q != IDLE);
    assign rsp_take = (state_q == WAIT) && mem_rsp_valid;
    assign rsp_keep = rsp_take && !discard_q;

    // A prefetch response is only useful while E0 is still its predecessor and fetch is hitting.
    assign pf_match = e0_valid && (e0_tag == req_tag - 30'd1);
    assign fill0_en = rsp_keep && !req_is_pf_q;
    assign fill1_en = rsp_keep && req_is_pf_q && pf_match && !mem_stall;

    assign pf_want   = PREFETCH && e0_hit && !e1_valid && !e0_err;
    assign stale_req = req_is_pf_q || (req_tag != fetch_tag);

    imem_stream_buf u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .fetch_tag (fetch_tag),
        .inv_all   (mem_stall),
        .fill0_en  (fill0_en),
        .fill1_en  (fill1_en),
        .fill_tag  (req_tag),
        .fill_data (mem_rsp_data),
        .fill_err  (mem_rsp_err),
        .hit       (hit),
        .hit_data  (hit_data),
        .hit_err   (hit_err),
        .e0_hit    (e0_hit),
        .e0_valid  (e0_valid),
        .e0_tag    (e0_tag),
        .e0_err    (e0_err),
        .e1_valid  (e1_valid)
    );

    // An in-flight request that no longer serves the missing PC is flagged so its response is dropped.
    always_comb begin
        discard_d = discard_q;
        if (rsp_take) begin
            discard_d = 1'b0;
        end else if (busy && mem_stall && stale_req) begin
            discard_d = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        req_is_pf_d = req_is_pf_q;
        case (state_q)
            IDLE: begin
                if (mem_stall) begin
                    state_d     = REQ;
                    req_addr_d  = tag_to_addr(fetch_tag);
                    req_is_pf_d = 1'b0;
                end else if (pf_want) begin
                    state_d     = REQ;
                    req_addr_d  = tag_to_addr(e0_tag + 30'd1);
                    req_is_pf_d = 1'b1;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_addr_q  <= 32'h0;
            req_is_pf_q <= 1'b0;
            discard_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            req_is_pf_q <= req_is_pf_d;
            discard_q   <= discard_d;
        end
    end

endmodule
